// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and the legal register-width range.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 64;

  function automatic logic is_shift(input shift_mode_e mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Bundle of the data/control signals around one universal shift register.
// Clock and reset stay outside the bundle.
interface shift_reg_if #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) ();
  import shift_reg_pkg::*;

  logic              clear;
  logic              enable;
  shift_mode_e       mode;
  logic              serial_right;
  logic              serial_left;
  logic [WIDTH-1:0]  par_in;
  logic [WIDTH-1:0]  par_out;
  logic              ser_r_out;
  logic              ser_l_out;
  logic [CNT_W-1:0]  count;
  logic              valid;

  modport master (
    output clear, enable, mode, serial_right, serial_left, par_in,
    input  par_out, ser_r_out, ser_l_out, count, valid
  );

  modport slave (
    input  clear, enable, mode, serial_right, serial_left, par_in,
    output par_out, ser_r_out, ser_l_out, count, valid
  );

endinterface

// File: rtl/shift_bit_counter.sv
// Counts shifts within the current word; wrap flags the shift that completes
// a word. Falling-edge clocked, asynchronous active-low reset.
module shift_bit_counter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_wrap;

  assign w_wrap = inc && (r_count == LAST);

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear || w_wrap) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign wrap  = w_wrap;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with a per-word shift counter and a one-cycle word-complete pulse.
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk_In,
  input  logic             Reset_N_In,
  input  logic             Clear_In,
  input  logic             Enable_In,
  input  logic [1:0]       Mode_In,
  input  logic             Serial_Right_In,
  input  logic             Serial_Left_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  output logic [WIDTH-1:0] Parallel_Data_Out,
  output logic             Serial_Right_Out,
  output logic             Serial_Left_Out,
  output logic [CNT_W-1:0] Bit_Count_Out,
  output logic             Word_Valid_Out
);

  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_width_check
    $error("universal_shift_register: WIDTH out of range");
  end

  shift_mode_e      w_mode;
  logic             w_active;
  logic             w_shift;
  logic             w_load;
  logic             w_cnt_clear;
  logic             w_wrap;
  logic [CNT_W-1:0] w_count;
  logic [WIDTH-1:0] w_data_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign w_mode      = shift_mode_e'(Mode_In);
  assign w_active    = !Clear_In && Enable_In;
  assign w_shift     = w_active && is_shift(w_mode);
  assign w_load      = w_active && (w_mode == MODE_LOAD);
  assign w_cnt_clear = Clear_In || w_load;

  always_comb begin
    w_data_nxt = r_data;
    if (Clear_In) begin
      w_data_nxt = '0;
    end else if (Enable_In) begin
      case (w_mode)
        MODE_SHR:  w_data_nxt = {Serial_Right_In, r_data[WIDTH-1:1]};
        MODE_SHL:  w_data_nxt = {r_data[WIDTH-2:0], Serial_Left_In};
        MODE_LOAD: w_data_nxt = Parallel_Data_In;
        default:   w_data_nxt = r_data;
      endcase
    end
  end

  // wrap is already gated by an enabled, non-cleared shift, so it alone
  // decides the pulse.
  always_ff @(negedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_data_nxt;
      r_valid <= w_wrap;
    end
  end

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clock (Clk_In),
    .reset (Reset_N_In),
    .clear (w_cnt_clear),
    .inc   (w_shift),
    .count (w_count),
    .wrap  (w_wrap)
  );

  assign Parallel_Data_Out = r_data;
  assign Serial_Right_Out  = r_data[0];
  assign Serial_Left_Out   = r_data[WIDTH-1];
  assign Bit_Count_Out     = w_count;
  assign Word_Valid_Out    = r_valid;

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL have derived constant CNT_W = clog2(WIDTH), bit-counter width.
REQ-003 SHALL have port Clk_In, input, 1, the single clock; all state changes on its falling edge.
REQ-004 SHALL have port Reset_N_In, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Clear_In, input, 1, synchronous clear of data, counter and valid.
REQ-006 SHALL have port Enable_In, input, 1, operation enable; low means hold.
REQ-007 SHALL have port Mode_In, input, 2, operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 SHALL have port Serial_Right_In, input, 1, bit entering at MSB on shift right.
REQ-009 SHALL have port Serial_Left_In, input, 1, bit entering at LSB on shift left.
REQ-010 SHALL have port Parallel_Data_In, input, WIDTH, load value.
REQ-011 SHALL have port Parallel_Data_Out, output, WIDTH, current register contents.
REQ-012 SHALL have port Serial_Right_Out, output, 1, combinational copy of register bit 0.
REQ-013 SHALL have port Serial_Left_Out, output, 1, combinational copy of register bit WIDTH-1.
REQ-014 SHALL have port Bit_Count_Out, output, CNT_W, shifts completed in the current word.
REQ-015 SHALL have port Word_Valid_Out, output, 1, one-cycle pulse when a full word has been shifted.

Function
REQ-016 Priority per falling edge SHALL be: Clear_In > Enable_In low > Mode_In.
REQ-017 Clear_In high SHALL set register, Bit_Count_Out and Word_Valid_Out to 0.
REQ-018 Enable_In low or Mode 00 SHALL leave register and Bit_Count_Out unchanged and drive Word_Valid_Out 0.
REQ-019 Mode 01 SHALL do reg <= {Serial_Right_In, reg[WIDTH-1:1]}.
REQ-020 Mode 10 SHALL do reg <= {reg[WIDTH-2:0], Serial_Left_In}.
REQ-021 Mode 11 SHALL do reg <= Parallel_Data_In, Bit_Count_Out <= 0, Word_Valid_Out <= 0.
REQ-022 Each shift (mode 01 or 10) SHALL increment Bit_Count_Out; at WIDTH-1 it SHALL wrap to 0 on that shift.
REQ-023 Word_Valid_Out SHALL be 1 for exactly the cycle following the wrapping shift, else 0; back-to-back words give one pulse every WIDTH shifts.
REQ-024 Mixing shift directions within a word SHALL count every shift; the counter is direction-agnostic.
REQ-025 Latency: Parallel_Data_Out and serial outputs SHALL reflect an operation immediately after the edge that performs it.

Reset
REQ-026 Reset_N_In low SHALL immediately, independent of Clk_In, force register, Bit_Count_Out and Word_Valid_Out to 0 (so serial outputs 0).
REQ-027 Reset asserted mid-word SHALL discard the partial word; counting restarts from 0 after release.
REQ-028 The first falling edge after release SHALL perform the selected operation normally.

Structure
REQ-029 Mode encodings (HOLD, SHR, SHL, LOAD) SHALL live in shared package shift_reg_pkg.
REQ-030 Bit counter with wrap detect SHALL be sub-module shift_bit_counter (params WIDTH; ports clock, reset, clear, inc, count, wrap).
REQ-031 Data path and Word_Valid_Out register SHALL reside in universal_shift_register.

Verification (WIDTH=8)
REQ-032 Reset low asynchronously mid-cycle after loading 8'hFF -> all outputs 0 before next clock edge.
REQ-033 Mode 01, Serial_Right_In 1,0,1,1,0,0,1,0 over 8 edges -> Parallel_Data_Out 8'h4D, Word_Valid_Out high one cycle only, Bit_Count_Out 0.
REQ-034 Load 8'hA5, then one Mode 10 shift with Serial_Left_In 0 -> Serial_Left_Out 1 before shift, Parallel_Data_Out 8'h4A after, Bit_Count_Out 1.
REQ-035 After 5 shifts, Enable_In low 3 cycles -> data and Bit_Count_Out (5) unchanged, no valid; 3 further shifts -> valid pulse.
REQ-036 After 5 shifts, Clear_In high with Mode 01 -> data 0, count 0, no valid; subsequent 8 shifts -> exactly one valid pulse.
REQ-037 16 consecutive Mode 01 shifts -> exactly two Word_Valid_Out pulses, 8 cycles apart.
